mostra_sequencia: RTL and testbench



---
 rtl/mostra_sequencia_pkg.sv | 16 +
 rtl/mostra_sequencia_temporizador.sv | 30 +++
 rtl/mostra_sequencia.sv | 127 ++++++++++++
 tb/tb_mostra_sequencia.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mostra_sequencia_pkg.sv
// rtl/mostra_sequencia_pkg.sv - state codes and default timing shared with the game top level
package mostra_sequencia_pkg;

    typedef enum logic [2:0] {
        ST_INICIAL = 3'd0,
        ST_CARREGA = 3'd1,
        ST_ACENDE  = 3'd2,
        ST_APAGA   = 3'd3,
        ST_PROXIMO = 3'd4,
        ST_FIM     = 3'd5
    } estado_t;

    localparam int T_ON_PADRAO  = 1000;
    localparam int T_OFF_PADRAO = 500;

endpackage

// File: rtl/mostra_sequencia_temporizador.sv
// rtl/mostra_sequencia_temporizador.sv - temporizador_mostra: lit/blank interval counter
module temporizador_mostra #(
    parameter int CNT_W = 16,
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500
) (
    input  logic clock,
    input  logic reset,
    input  logic i_limpa,
    input  logic i_conta,
    input  logic i_sel_off,
    output logic o_fim_tempo
);

    localparam logic [CNT_W-1:0] TERM_ON  = CNT_W'(T_ON - 1);
    localparam logic [CNT_W-1:0] TERM_OFF = CNT_W'(T_OFF - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset || i_limpa) begin
            r_cnt <= '0;
        end else if (i_conta) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_fim_tempo = (r_cnt == (i_sel_off ? TERM_OFF : TERM_ON));

endmodule

// File: rtl/mostra_sequencia.sv
// rtl/mostra_sequencia.sv - plays the round's sequence on the LEDs; MOSTRA_SEQUENCIA_ABORTA_EN adds an abort input
module mostra_sequencia
    import mostra_sequencia_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int LED_W  = 4,
    parameter int T_ON   = T_ON_PADRAO,
    parameter int T_OFF  = T_OFF_PADRAO,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
    input  logic              aborta,
`endif
    input  logic [ADDR_W-1:0] limite,
    input  logic [LED_W-1:0]  dado,
    output logic [ADDR_W-1:0] endereco,
    output logic [LED_W-1:0]  leds,
    output logic              mostrando,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    estado_t           r_estado;
    estado_t           w_prox;
    logic [ADDR_W-1:0] r_endereco;
    logic [ADDR_W-1:0] r_limite;
    logic [LED_W-1:0]  r_dado;
    logic              w_limpa;
    logic              w_conta;
    logic              w_sel_off;
    logic              w_fim_tempo;

    temporizador_mostra #(
        .CNT_W (CNT_W),
        .T_ON  (T_ON),
        .T_OFF (T_OFF)
    ) u_temporizador (
        .clock       (clock),
        .reset       (reset),
        .i_limpa     (w_limpa),
        .i_conta     (w_conta),
        .i_sel_off   (w_sel_off),
        .o_fim_tempo (w_fim_tempo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= ST_INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox    = r_estado;
        w_limpa   = 1'b0;
        w_conta   = 1'b0;
        w_sel_off = 1'b0;
        case (r_estado)
            ST_INICIAL: begin
                if (iniciar) begin
                    w_limpa = 1'b1;
                    w_prox  = ST_CARREGA;
                end
            end
            ST_CARREGA: begin
                w_limpa = 1'b1;
                w_prox  = ST_ACENDE;
            end
            ST_ACENDE: begin
                w_conta = 1'b1;
                if (w_fim_tempo) begin
                    w_limpa = 1'b1;
                    w_prox  = ST_APAGA;
                end
            end
            ST_APAGA: begin
                w_conta   = 1'b1;
                w_sel_off = 1'b1;
                if (w_fim_tempo) begin
                    w_limpa = 1'b1;
                    w_prox  = (r_endereco == r_limite) ? ST_FIM : ST_PROXIMO;
                end
            end
            ST_PROXIMO: w_prox = ST_CARREGA;
            ST_FIM:     w_prox = ST_INICIAL;
            default:    w_prox = ST_INICIAL;
        endcase
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        if (aborta && (r_estado != ST_INICIAL)) begin
            w_limpa = 1'b1;
            w_prox  = ST_INICIAL;
        end
`endif
    end

    // Any return to inicial (end, abort, illegal code) parks the address at 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_endereco <= '0;
            r_limite   <= '0;
            r_dado     <= '0;
        end else begin
            if (w_prox == ST_INICIAL) begin
                r_endereco <= '0;
            end else if (r_estado == ST_PROXIMO) begin
                r_endereco <= r_endereco + ADDR_W'(1);
            end
            if ((r_estado == ST_INICIAL) && iniciar) begin
                r_limite <= limite;
            end
            if (r_estado == ST_CARREGA) begin
                r_dado <= dado;
            end
        end
    end

    assign endereco  = r_endereco;
    assign leds      = (r_estado == ST_ACENDE) ? r_dado : '0;
    assign mostrando = (r_estado != ST_INICIAL);
    assign pronto    = (r_estado == ST_FIM);
    assign db_estado = r_estado;

endmodule

// File: tb/tb_mostra_sequencia.sv
// tb/tb_mostra_sequencia.sv - directed bench for mostra_sequencia with T_ON=3, T_OFF=2
module tb_mostra_sequencia;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       mostrando;
    logic       pronto;
    logic [2:0] db_estado;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
    logic       aborta;
`endif

    logic [3:0] mem [16];
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    assign dado = mem[endereco];

    mostra_sequencia #(
        .ADDR_W (4),
        .LED_W  (4),
        .T_ON   (3),
        .T_OFF  (2),
        .CNT_W  (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        .aborta    (aborta),
`endif
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .mostrando (mostrando),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_estado"}, 32'(db_estado), 0);
        chk({tag, "_leds"}, 32'(leds), 0);
        chk({tag, "_end"}, 32'(endereco), 0);
        chk({tag, "_mostrando"}, 32'(mostrando), 0);
        chk({tag, "_pronto"}, 32'(pronto), 0);
    endtask

    // Entered on the cycle right after the edge that sampled iniciar.
    task automatic check_playback(input string tag, input int n);
        int busy = 0;
        int npronto = 0;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_carrega_st"}, 32'(db_estado), 1);
            chk({tag, "_carrega_end"}, 32'(endereco), k);
            chk({tag, "_carrega_leds"}, 32'(leds), 0);
            if (mostrando) busy++;
            tick();
            for (int j = 0; j < 3; j++) begin
                chk({tag, "_acende_st"}, 32'(db_estado), 2);
                chk({tag, "_acende_leds"}, 32'(leds), 32'(mem[k]));
                chk({tag, "_acende_end"}, 32'(endereco), k);
                if (mostrando) busy++;
                tick();
            end
            for (int j = 0; j < 2; j++) begin
                chk({tag, "_apaga_st"}, 32'(db_estado), 3);
                chk({tag, "_apaga_leds"}, 32'(leds), 0);
                if (mostrando) busy++;
                if (pronto) npronto++;
                tick();
            end
            chk({tag, "_fim_prox_st"}, 32'(db_estado), (k == n - 1) ? 5 : 4);
            if (mostrando) busy++;
            if (pronto) npronto++;
            tick();
        end
        chk({tag, "_busy"}, 32'(busy), 7 * n);
        chk({tag, "_npronto"}, 32'(npronto), 1);
        chk_idle({tag, "_after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        mem = '{default: 4'h0};
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
        reset = 1'b1; iniciar = 1'b0; limite = 4'd0;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        aborta = 1'b0;
`endif
        tick(); tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        chk_idle("idle");

        // single item
        limite = 4'd0; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check_playback("single", 1);

        // full round
        limite = 4'd3; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check_playback("full", 4);

        // iniciar held high and limite changed after start
        limite = 4'd3; iniciar = 1'b1;
        tick();
        limite = 4'd1;
        check_playback("hold", 4);
        iniciar = 1'b0;
        tick();
        chk_idle("hold_idle");

        // reset during second item's acende
        limite = 4'd3; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("rst_pre_st", 32'(db_estado), 2);
        chk("rst_pre_end", 32'(endereco), 1);
        chk("rst_pre_leds", 32'(leds), 32'(4'b0010));
        reset = 1'b1;
        tick();
        chk_idle("rst_mid");
        reset = 1'b0;
        tick();
        chk_idle("rst_mid2");

        // zero data keeps timing
        mem[0] = 4'b0000;
        limite = 4'd0; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check_playback("zero", 1);
        mem[0] = 4'b0001;

        // last address with no wrap
        for (int i = 4; i < 16; i++) mem[i] = 4'(i);
        limite = 4'd15; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check_playback("maxaddr", 16);

`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        limite = 4'd3; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_pre_st", 32'(db_estado), 3);
        aborta = 1'b1;
        tick();
        aborta = 1'b0;
        chk_idle("abort");
        tick();
        chk_idle("abort2");
        limite = 4'd3; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check_playback("abort_replay", 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
